// File: rtl/hiscore_pkg.sv
// Shared types and default constants for the hiscore save/restore bridge.
package hiscore_pkg;

    localparam int unsigned RAM_AW = 10;

    localparam logic [7:0]        HS_INDEX_DEF  = 8'd3;
    localparam logic [RAM_AW-1:0] HS_START_DEF  = 10'h002;
    localparam logic [RAM_AW-1:0] HS_LENGTH_DEF = 10'd33;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UPLOAD   = 2'd1,
        DOWNLOAD = 2'd2
    } hs_state_t;

endpackage

// File: rtl/hiscore_if.sv
// HPS ioctl file-transfer bus; master is the HPS side, slave is the controller.
interface hiscore_if;

    logic        ioctl_upload;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  ioctl_index;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;

    modport master (
        output ioctl_upload, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        input  ioctl_din, ioctl_wait
    );

    modport slave (
        input  ioctl_upload, ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index,
        output ioctl_din, ioctl_wait
    );

endinterface

// File: rtl/hiscore_wait_timer.sv
// Reloadable down-counter; busy stays high for LOAD_VAL cycles after each load.
module hiscore_wait_timer #(
    parameter int unsigned LOAD_VAL = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic busy
);

    localparam int unsigned CW = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (load)
            cnt <= CW'(LOAD_VAL);
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hiscore_ctrl.sv
// Bridges the ioctl file bus onto a window of game work RAM for hiscore save/restore.
// Optional HISCORE_PAUSE_EN adds pause_cpu to hold the core off RAM during transfers.
module hiscore_ctrl
    import hiscore_pkg::*;
#(
    parameter logic [7:0]        HS_INDEX  = HS_INDEX_DEF,
    parameter logic [RAM_AW-1:0] HS_START  = HS_START_DEF,
    parameter logic [RAM_AW-1:0] HS_LENGTH = HS_LENGTH_DEF,
    parameter int unsigned       READ_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    hiscore_if.slave          ioctl,
    input  logic [7:0]        ram_rdata,
    output logic [RAM_AW-1:0] ram_address,
    output logic [7:0]        ram_wdata,
    output logic              ram_we
`ifdef HISCORE_PAUSE_EN
    ,
    output logic              pause_cpu
`endif
);

    hs_state_t   state, state_n;
    logic        sel, in_range, in_range_q, conflict;
    logic [24:0] addr_q;
    logic        wait_load, wait_clear, wait_busy;

    assign sel      = (ioctl.ioctl_index == HS_INDEX);
    assign in_range = (ioctl.ioctl_addr < {15'b0, HS_LENGTH});
    assign conflict = ioctl.ioctl_upload & ioctl.ioctl_download;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (ioctl.ioctl_upload && !ioctl.ioctl_download && sel)
                    state_n = UPLOAD;
                else if (ioctl.ioctl_download && !ioctl.ioctl_upload && sel)
                    state_n = DOWNLOAD;
            end
            UPLOAD:
                if (!ioctl.ioctl_upload || !sel || conflict) state_n = IDLE;
            DOWNLOAD:
                if (!ioctl.ioctl_download || !sel || conflict) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Address, write strobe and range flag follow the next state so the entry
    // cycle already presents the window address and the exit cycle returns to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ram_address <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            in_range_q  <= 1'b0;
            addr_q      <= '0;
        end else begin
            state  <= state_n;
            addr_q <= ioctl.ioctl_addr;
            ram_we <= 1'b0;
            if (state_n == IDLE) begin
                ram_address <= '0;
                in_range_q  <= 1'b0;
            end else begin
                ram_address <= in_range ? (HS_START + ioctl.ioctl_addr[RAM_AW-1:0]) : HS_START;
                in_range_q  <= in_range;
            end
            if (state_n == DOWNLOAD && ioctl.ioctl_wr && in_range) begin
                ram_we    <= 1'b1;
                ram_wdata <= ioctl.ioctl_dout;
            end
        end
    end

    assign wait_clear = (state_n != UPLOAD);
    assign wait_load  = (state_n == UPLOAD) &&
                        ((state != UPLOAD) || (ioctl.ioctl_addr != addr_q));

    hiscore_wait_timer #(
        .LOAD_VAL (READ_LAT)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .clear (wait_clear),
        .busy  (wait_busy)
    );

    assign ioctl.ioctl_wait = wait_busy;
    assign ioctl.ioctl_din  = (state == UPLOAD && in_range_q) ? ram_rdata : 8'h00;

`ifdef HISCORE_PAUSE_EN
    logic [2:0] pause_cnt;

    // Tail counter keeps the core paused for 4 cycles after IDLE is re-entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pause_cnt <= '0;
            pause_cpu <= 1'b0;
        end else if (state_n != IDLE) begin
            pause_cnt <= 3'd4;
            pause_cpu <= 1'b1;
        end else begin
            pause_cpu <= (pause_cnt != '0);
            if (pause_cnt != '0)
                pause_cnt <= pause_cnt - 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hiscore_ctrl.sv
// Directed self-checking bench for hiscore_ctrl (HISCORE_PAUSE_EN section optional).
module tb_hiscore_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ram_rdata;
    logic [9:0] ram_address;
    logic [7:0] ram_wdata;
    logic       ram_we;
`ifdef HISCORE_PAUSE_EN
    logic       pause_cpu;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    hiscore_if hif ();

    hiscore_ctrl #(
        .HS_INDEX  (8'd3),
        .HS_START  (10'h002),
        .HS_LENGTH (10'd33),
        .READ_LAT  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ioctl       (hif),
        .ram_rdata   (ram_rdata),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we)
`ifdef HISCORE_PAUSE_EN
        ,
        .pause_cpu   (pause_cpu)
`endif
    );

    always #5 clk = ~clk;

    // Game RAM stand-in: each location reads back as its low address byte inverted.
    assign ram_rdata = ram_address[7:0] ^ 8'hFF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        hif.ioctl_upload   = 1'b0;
        hif.ioctl_download = 1'b0;
        hif.ioctl_wr       = 1'b0;
        hif.ioctl_addr     = '0;
        hif.ioctl_dout     = '0;
        hif.ioctl_index    = 8'd0;

        #1 reset = 1'b1;
        #1;
        chk("rst_addr", 32'(ram_address), 32'h0);
        chk("rst_we", 32'(ram_we), 32'h0);
        chk("rst_wdata", 32'(ram_wdata), 32'h0);
        chk("rst_wait", 32'(hif.ioctl_wait), 32'h0);
        chk("rst_din", 32'(hif.ioctl_din), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
`ifdef HISCORE_PAUSE_EN
        chk("pause_idle", 32'(pause_cpu), 32'h0);
`endif

        // Download: in-range writes, back to back
        hif.ioctl_index    = 8'd3;
        hif.ioctl_download = 1'b1;
        hif.ioctl_addr     = 25'd0;
        tick();
        chk("dl_entry_we", 32'(ram_we), 32'h0);
        chk("dl_entry_addr", 32'(ram_address), 32'h002);
        hif.ioctl_wr   = 1'b1;
        hif.ioctl_addr = 25'd0;
        hif.ioctl_dout = 8'hA5;
        tick();
        chk("dl_w0_we", 32'(ram_we), 32'h1);
        chk("dl_w0_addr", 32'(ram_address), 32'h002);
        chk("dl_w0_data", 32'(ram_wdata), 32'hA5);
        chk("dl_wait", 32'(hif.ioctl_wait), 32'h0);
        hif.ioctl_addr = 25'd32;
        hif.ioctl_dout = 8'h5A;
        tick();
        chk("dl_w32_we", 32'(ram_we), 32'h1);
        chk("dl_w32_addr", 32'(ram_address), 32'h022);
        chk("dl_w32_data", 32'(ram_wdata), 32'h5A);
        hif.ioctl_wr = 1'b0;
        tick();
        chk("dl_pulse_end", 32'(ram_we), 32'h0);

        // Download: out-of-range addresses, including upper bits
        hif.ioctl_wr   = 1'b1;
        hif.ioctl_addr = 25'd33;
        hif.ioctl_dout = 8'h11;
        tick();
        chk("dl_oor33_we", 32'(ram_we), 32'h0);
        chk("dl_oor33_addr", 32'(ram_address), 32'h002);
        hif.ioctl_addr = 25'h1000002;
        tick();
        chk("dl_oor_hi_we", 32'(ram_we), 32'h0);
        chk("dl_oor_hi_addr", 32'(ram_address), 32'h002);
        chk("dl_oor_data_kept", 32'(ram_wdata), 32'h5A);

        // Reset asserted mid-download with a live write strobe
        hif.ioctl_addr = 25'd5;
        hif.ioctl_dout = 8'h77;
        tick();
        chk("dl_w5_we", 32'(ram_we), 32'h1);
        chk("dl_w5_addr", 32'(ram_address), 32'h007);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_we", 32'(ram_we), 32'h0);
        chk("async_rst_addr", 32'(ram_address), 32'h0);
        chk("async_rst_wait", 32'(hif.ioctl_wait), 32'h0);
        hif.ioctl_wr       = 1'b0;
        hif.ioctl_download = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        // Upload sweep across the window and one step past it
        hif.ioctl_upload = 1'b1;
        for (int a = 0; a <= 33; a++) begin
            hif.ioctl_addr = 25'(a);
            tick();
            chk($sformatf("ul_wait1_%0d", a), 32'(hif.ioctl_wait), 32'h1);
            tick();
            chk($sformatf("ul_wait2_%0d", a), 32'(hif.ioctl_wait), 32'h1);
            tick();
            chk($sformatf("ul_wait0_%0d", a), 32'(hif.ioctl_wait), 32'h0);
            if (a < 33)
                chk($sformatf("ul_din_%0d", a), 32'(hif.ioctl_din), 32'(8'((a + 2) ^ 8'hFF)));
            else
                chk("ul_din_oor", 32'(hif.ioctl_din), 32'h0);
            chk($sformatf("ul_we_%0d", a), 32'(ram_we), 32'h0);
        end
        hif.ioctl_upload = 1'b0;
        tick();
        chk("ul_exit_din", 32'(hif.ioctl_din), 32'h0);
        chk("ul_exit_addr", 32'(ram_address), 32'h0);
        chk("ul_exit_wait", 32'(hif.ioctl_wait), 32'h0);

        // Wrong index, then both strobes high: controller must stay idle
        hif.ioctl_index    = 8'd4;
        hif.ioctl_download = 1'b1;
        hif.ioctl_wr       = 1'b1;
        hif.ioctl_addr     = 25'd1;
        hif.ioctl_dout     = 8'hC3;
        tick();
        tick();
        chk("idx4_we", 32'(ram_we), 32'h0);
        chk("idx4_addr", 32'(ram_address), 32'h0);
        hif.ioctl_index  = 8'd3;
        hif.ioctl_upload = 1'b1;
        tick();
        tick();
        chk("both_we", 32'(ram_we), 32'h0);
        chk("both_addr", 32'(ram_address), 32'h0);
        chk("both_din", 32'(hif.ioctl_din), 32'h0);
        chk("both_wait", 32'(hif.ioctl_wait), 32'h0);
        hif.ioctl_upload   = 1'b0;
        hif.ioctl_download = 1'b0;
        hif.ioctl_wr       = 1'b0;
        tick();

`ifdef HISCORE_PAUSE_EN
        // Pause held through upload and for exactly 4 cycles after leaving it
        hif.ioctl_upload = 1'b1;
        hif.ioctl_addr   = 25'd0;
        tick();
        chk("pause_ul_0", 32'(pause_cpu), 32'h1);
        tick();
        tick();
        chk("pause_ul_2", 32'(pause_cpu), 32'h1);
        hif.ioctl_upload = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("pause_tail_%0d", c), 32'(pause_cpu), 32'h1);
        end
        tick();
        chk("pause_fall", 32'(pause_cpu), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hiscore_ctrl.md
Name: hiscore_ctrl

Overview:
- Bridges the HPS ioctl file-transfer bus to the game work RAM so high-score tables can be saved and restored.
- On upload (save), it maps the ioctl byte address onto a window of game RAM and returns the RAM read data.
- On download (restore), it turns ioctl write strobes into single-cycle RAM writes inside the same window.
- Sits beside the centipede core and drives the core's 10-bit debug/hiscore RAM address port.

Parameters:
- HS_INDEX, 8'd3: ioctl_index value that selects the hiscore file; any other index is ignored.
- HS_START, 10'h002: first game-RAM address of the hiscore window.
- HS_LENGTH, 10'd33: number of bytes in the window; valid offsets are 0..HS_LENGTH-1.
- READ_LAT, 2: number of cycles ioctl_wait is held after an upload address change.

Ports:
- clk  in  1  system clock (12 MHz core clock).
- reset  in  1  asynchronous, active-high reset.
- ioctl_upload  in  1  HPS is reading (saving) a file.
- ioctl_download  in  1  HPS is writing (restoring) a file.
- ioctl_wr  in  1  one-cycle write strobe during download.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  download data from the HPS.
- ioctl_index  in  8  file selector.
- ram_rdata  in  8  game RAM read data at ram_address (combinational RAM read).
- ioctl_din  out  8  upload data returned to the HPS.
- ioctl_wait  out  1  stall request to the HPS during upload.
- ram_address  out  10  game RAM address.
- ram_wdata  out  8  game RAM write data.
- ram_we  out  1  game RAM write enable, one-cycle pulse.

Behaviour:
- Reset (async, active-high): state=IDLE, ram_address=0, ram_wdata=0, ram_we=0, ioctl_wait=0, wait counter=0. All outputs go to their reset values immediately when reset asserts, even in mid-transfer.
- sel = (ioctl_index==HS_INDEX).
- in_range = (ioctl_addr < HS_LENGTH); the full 25-bit compare is used.
- States and transitions:
  - IDLE -> UPLOAD when ioctl_upload & ~ioctl_download & sel.
  - IDLE -> DOWNLOAD when ioctl_download & ~ioctl_upload & sel.
  - Any state -> IDLE when its strobe drops, when sel drops, or when upload and download are both high. In that last case the controller stays IDLE and does nothing.
- ram_address is registered:
  - In UPLOAD or DOWNLOAD: next ram_address = HS_START + ioctl_addr[9:0] when in_range, else HS_START. The sum is 10-bit modulo.
  - In IDLE: ram_address holds 0.
- UPLOAD:
  - ioctl_din = ram_rdata when the in_range value registered with ram_address is 1, else 8'h00.
  - ioctl_din is 8'h00 whenever state != UPLOAD.
  - Any change of ioctl_addr, including the entry cycle, loads the wait counter with READ_LAT. ioctl_wait = (counter != 0), and the counter decrements each cycle.
  - After ioctl_wait falls, ioctl_din is stable for the current ioctl_addr.
- DOWNLOAD:
  - On a cycle with ioctl_wr & in_range, the next cycle has ram_we=1 for exactly one cycle, ram_address = HS_START + offset, and ram_wdata = ioctl_dout.
  - ioctl_wr with an out-of-range address produces no write.
  - ioctl_wait stays 0.
  - Back-to-back ioctl_wr strobes produce back-to-back writes.
- ram_we is never asserted outside DOWNLOAD.

Optional Feature:
- Macro HISCORE_PAUSE_EN.
- When defined: add output pause_cpu (1 bit), reset 0. It is registered high while state is UPLOAD or DOWNLOAD and for 4 cycles after returning to IDLE, so the core cannot touch RAM mid-transfer.
- When undefined: the port and its logic are absent; the core runs freely during transfers.

Decomposition:
- Package hiscore_pkg holds:
  - the state enum (IDLE, UPLOAD, DOWNLOAD);
  - default constants HS_INDEX_DEF, HS_START_DEF, HS_LENGTH_DEF;
  - the ram address width constant, 10.
- One optional sub-module, hiscore_wait_timer, holds the reloadable down-counter that generates ioctl_wait. Everything else is a single module.

Test Plan:
- Reset asserted mid-DOWNLOAD with ioctl_wr=1 -> ram_we=0, ram_address=0, ioctl_wait=0 immediately, with no clock edge needed.
- Download, index 3, ioctl_wr at addr 0 with data 8'hA5, then addr 32 with 8'h5A -> ram_we pulses. The writes land at ram_address 10'h002 with 8'hA5 and 10'h022 with 8'h5A.
- Download, ioctl_wr at addr 33 and at addr 25'h1000002 -> no ram_we. The second case checks that the upper address bits are not truncated.
- Upload, index 3, RAM model returns addr^8'hFF, step addr 0..32 -> ioctl_wait is high for 2 cycles after each step, then ioctl_din = (HS_START+addr)^8'hFF. At addr 33, ioctl_din=8'h00.
- Download with index 4, then upload and download both high with index 3 -> state stays IDLE, no ram_we, ram_address=0, ioctl_din=0.
- With HISCORE_PAUSE_EN, upload then drop ioctl_upload -> pause_cpu is high throughout and falls exactly 4 cycles after IDLE is re-entered.
